decode_stage: RTL and testbench

- Instruction decode stage directly downstream of the fetch stage.
- Accepts 16-bit instruction words plus PC from fetch through a valid/ready handshake, and splits each word into opcode, register indices, sign-extended immediate and control flags.
- Presents the decoded result to execute through a registered output with a one-entry skid buffer, so back-pressure never drops an instruction.
- Counts retired-to-execute instructions.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - 16-bit instruction decode stage with registered output and one-entry skid buffer
// Decoded bundle is registered; the skid holds the raw word and PC and is decoded when promoted.
module decode_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] if_instr,
   input  logic [DATA_W-1:0] if_pc,
   output logic              if_ready,
   output logic              id_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] id_pc,
   output logic [3:0]        id_opcode,
   output logic [3:0]        id_rd,
   output logic [3:0]        id_rs1,
   output logic [3:0]        id_rs2,
   output logic [DATA_W-1:0] id_imm,
   output logic              id_rf_we,
   output logic              id_is_load,
   output logic              id_is_store,
   output logic              id_is_branch,
   output logic              id_is_jump,
   output logic              id_illegal,
   output logic [CNT_W-1:0]  id_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0]        opcode;
      logic [3:0]        rd;
      logic [3:0]        rs1;
      logic [3:0]        rs2;
      logic [DATA_W-1:0] imm;
      logic              rf_we;
      logic              is_load;
      logic              is_store;
      logic              is_branch;
      logic              is_jump;
      logic              illegal;
   } dec_t;

   state_t              state_q, state_d;
   dec_t                dec_q, dec_d, dec_w;
   logic [DATA_W-1:0]   id_pc_q, id_pc_d;
   logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
   logic [DATA_W-1:0]   skid_pc_q, skid_pc_d;
   logic [CNT_W-1:0]    id_count_q, id_count_d;
   logic [DATA_W-1:0]   src_instr, src_pc;
   logic                accept, deliver, load_out, load_skid;

   assign if_ready = (state_q != ST_FULL);
   assign id_valid = (state_q != ST_EMPTY);
   assign accept   = if_valid && if_ready;
   assign deliver  = id_valid && ex_ready;

   // The output register is refilled from the skid when one is held, otherwise from fetch.
   assign src_instr = (state_q == ST_FULL) ? skid_instr_q : if_instr;
   assign src_pc    = (state_q == ST_FULL) ? skid_pc_q    : if_pc;

   always_comb begin
      dec_w        = '0;
      dec_w.opcode = src_instr[15:12];
      dec_w.rd     = src_instr[11:8];
      dec_w.rs1    = src_instr[7:4];
      dec_w.rs2    = src_instr[3:0];
      case (src_instr[15:12])
         4'h0: ;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: dec_w.rf_we = 1'b1;
         4'h6: begin
            dec_w.rf_we = 1'b1;
            dec_w.rs1   = src_instr[11:8];
            dec_w.imm   = {{8{src_instr[7]}}, src_instr[7:0]};
         end
         4'h7: begin
            dec_w.rf_we = 1'b1;
            dec_w.imm   = {src_instr[7:0], 8'h00};
         end
         4'h8: begin
            dec_w.rf_we   = 1'b1;
            dec_w.is_load = 1'b1;
            dec_w.imm     = {{12{src_instr[3]}}, src_instr[3:0]};
         end
         4'h9: begin
            dec_w.is_store = 1'b1;
            dec_w.rd       = 4'h0;
            dec_w.rs2      = src_instr[11:8];
            dec_w.imm      = {{12{src_instr[3]}}, src_instr[3:0]};
         end
         4'hA: begin
            dec_w.is_branch = 1'b1;
            dec_w.rd        = 4'h0;
            dec_w.rs1       = src_instr[11:8];
            dec_w.rs2       = src_instr[7:4];
            dec_w.imm       = {{12{src_instr[3]}}, src_instr[3:0]};
         end
         4'hB: begin
            dec_w.is_jump = 1'b1;
            dec_w.rd      = 4'h0;
            dec_w.rs1     = 4'h0;
            dec_w.rs2     = 4'h0;
            dec_w.imm     = {{4{src_instr[11]}}, src_instr[11:0]};
         end
         4'hC, 4'hD, 4'hE, 4'hF: dec_w.illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      load_skid = 1'b0;
      // Flush wins over any concurrent accept or deliver.
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  load_out = 1'b1;
                  state_d  = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (accept && deliver) begin
                  load_out = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_d   = ST_FULL;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (deliver) begin
                  load_out = 1'b1;
                  state_d  = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      dec_d        = load_out ? dec_w : dec_q;
      id_pc_d      = load_out ? src_pc : id_pc_q;
      skid_instr_d = load_skid ? if_instr : skid_instr_q;
      skid_pc_d    = load_skid ? if_pc : skid_pc_q;
      id_count_d   = id_count_q + {{(CNT_W-1){1'b0}}, (deliver && !flush)};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         dec_q        <= '0;
         id_pc_q      <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         id_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         dec_q        <= dec_d;
         id_pc_q      <= id_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         id_count_q   <= id_count_d;
      end
   end

   assign id_pc        = id_pc_q;
   assign id_opcode    = dec_q.opcode;
   assign id_rd        = dec_q.rd;
   assign id_rs1       = dec_q.rs1;
   assign id_rs2       = dec_q.rs2;
   assign id_imm       = dec_q.imm;
   assign id_rf_we     = dec_q.rf_we;
   assign id_is_load   = dec_q.is_load;
   assign id_is_store  = dec_q.is_store;
   assign id_is_branch = dec_q.is_branch;
   assign id_is_jump   = dec_q.is_jump;
   assign id_illegal   = dec_q.illegal;
   assign id_count     = id_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
// Two-entry FIFO reference model plus directed constant expectations.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, if_valid, ex_ready;
   logic [15:0] if_instr, if_pc;
   logic        if_ready, id_valid;
   logic [15:0] id_pc, id_imm, id_count;
   logic [3:0]  id_opcode, id_rd, id_rs1, id_rs2;
   logic        id_rf_we, id_is_load, id_is_store, id_is_branch, id_is_jump, id_illegal;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
      .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc),
      .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_imm(id_imm), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
      .id_is_store(id_is_store), .id_is_branch(id_is_branch),
      .id_is_jump(id_is_jump), .id_illegal(id_illegal), .id_count(id_count)
   );

   typedef struct packed {
      logic [3:0]  op, rd, rs1, rs2;
      logic [15:0] imm;
      logic        we, ld, st, br, jp, ill;
   } dec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic [15:0] m_cnt;
   logic [15:0] saved_cnt;

   function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
      logic [15:0] m = 16'(1 << bits);
      v = v & (m - 16'd1);
      return (v >= (m >> 1)) ? v - m : v;
   endfunction

   function automatic dec_t ref_decode(input logic [15:0] w);
      dec_t e = '0;
      int   op = int'(w[15:12]);
      e.op  = w[15:12];
      e.rd  = w[11:8];
      e.rs1 = w[7:4];
      e.rs2 = w[3:0];
      if (op >= 1 && op <= 5) e.we = 1'b1;
      else if (op == 6) begin e.we = 1'b1; e.rs1 = w[11:8]; e.imm = sext(w, 8); end
      else if (op == 7) begin e.we = 1'b1; e.imm = w * 16'd256; end
      else if (op == 8) begin e.we = 1'b1; e.ld = 1'b1; e.imm = sext(w, 4); end
      else if (op == 9) begin e.st = 1'b1; e.rd = 4'h0; e.rs2 = w[11:8]; e.imm = sext(w, 4); end
      else if (op == 10) begin
         e.br = 1'b1; e.rd = 4'h0; e.rs1 = w[11:8]; e.rs2 = w[7:4]; e.imm = sext(w, 4);
      end
      else if (op == 11) begin e.jp = 1'b1; e.rd = 4'h0; e.rs1 = 4'h0; e.rs2 = 4'h0; e.imm = sext(w, 12); end
      else if (op >= 12) e.ill = 1'b1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dut_fields();
      return 64'({id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_rf_we, id_is_load,
                  id_is_store, id_is_branch, id_is_jump, id_illegal});
   endfunction

   task automatic observe();
      chk("if_ready", 64'(if_ready), 64'(q.size() < 2));
      chk("id_valid", 64'(id_valid), 64'(q.size() > 0));
      chk("id_count", 64'(id_count), 64'(m_cnt));
      if (q.size() > 0) begin
         chk("id_pc", 64'(id_pc), 64'(q[0][31:16]));
         chk("id_fields", dut_fields(), 64'(ref_decode(q[0][15:0])));
      end
   endtask

   // Called and returning at a falling edge: check, drive, update model, clock.
   task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl);
      logic acc, dlv;
      observe();
      if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
      acc = v && (q.size() < 2);
      dlv = (q.size() > 0) && rdy;
      if (fl) q.delete();
      else begin
         if (dlv) begin void'(q.pop_front()); m_cnt = m_cnt + 16'd1; end
         if (acc) q.push_back({pc, ins});
      end
      @(posedge clk);
      @(negedge clk);
      if_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; if_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
      if_instr = 16'($urandom); if_pc = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; if_valid = 1'b0;
      q.delete();
      m_cnt = 16'd0;
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);
      chk("rst_id_count", 64'(id_count), 64'd0);
      chk("rst_fields", dut_fields(), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
      if_instr = 16'h0; if_pc = 16'h0; m_cnt = 16'd0;
      @(negedge clk);
      do_reset();

      step(1'b1, 16'h1123, 16'h0010, 1'b1, 1'b0);
      chk("t1_valid", 64'(id_valid), 64'd1);
      chk("t1_op_regs", 64'({id_opcode, id_rd, id_rs1, id_rs2}), 64'h1123);
      chk("t1_we", 64'(id_rf_we), 64'd1);
      chk("t1_pc", 64'(id_pc), 64'h0010);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("t1_count", 64'(id_count), 64'd1);

      step(1'b1, 16'h66F0, 16'h0020, 1'b1, 1'b0);
      chk("addi_rd_rs1", 64'({id_rd, id_rs1}), 64'h66);
      chk("addi_imm", 64'(id_imm), 64'hFFF0);
      chk("addi_we", 64'(id_rf_we), 64'd1);
      step(1'b1, 16'hBFFE, 16'h0022, 1'b1, 1'b0);
      chk("jmp_flag", 64'(id_is_jump), 64'd1);
      chk("jmp_imm", 64'(id_imm), 64'hFFFE);
      step(1'b1, 16'hE000, 16'h0024, 1'b1, 1'b0);
      chk("illegal", 64'(id_illegal), 64'd1);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      step(1'b1, 16'h1000, 16'h0100, 1'b0, 1'b0);
      step(1'b1, 16'h2000, 16'h0102, 1'b0, 1'b0);
      chk("bp_full_ready", 64'(if_ready), 64'd0);
      step(1'b1, 16'h3000, 16'h0104, 1'b0, 1'b0);
      chk("bp_hold_op", 64'(id_opcode), 64'd1);
      step(1'b1, 16'h3000, 16'h0104, 1'b1, 1'b0);
      chk("bp_second_op", 64'(id_opcode), 64'd2);
      step(1'b1, 16'h3000, 16'h0104, 1'b1, 1'b0);
      chk("bp_third_op", 64'(id_opcode), 64'd3);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("bp_drained", 64'(id_valid), 64'd0);

      step(1'b1, 16'h4000, 16'h0200, 1'b0, 1'b0);
      step(1'b1, 16'h5000, 16'h0202, 1'b0, 1'b0);
      saved_cnt = id_count;
      step(1'b1, 16'h6000, 16'h0204, 1'b1, 1'b1);
      chk("fl_valid", 64'(id_valid), 64'd0);
      chk("fl_ready", 64'(if_ready), 64'd1);
      chk("fl_count", 64'(id_count), 64'(saved_cnt));
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("fl_gone", 64'(id_valid), 64'd0);

      for (int i = 0; i < 1500; i++)
         step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 31) == 0));

      n = 0;
      while (m_cnt != 16'hFFFF && n < 70000) begin
         step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
         n++;
      end
      chk("wrap_pre", 64'(id_count), 64'hFFFF);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk("wrap_zero", 64'(id_count), 64'd0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      step(1'b1, 16'h7012, 16'h0300, 1'b0, 1'b0);
      step(1'b1, 16'h8345, 16'h0302, 1'b0, 1'b0);
      chk("rf_full", 64'(if_ready), 64'd0);
      do_reset();
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
